touch_detect: RTL and testbench



---
 rtl/touch_pkg.sv | 16 +
 rtl/touch_baseline_iir.sv | 61 ++++++
 rtl/touch_detect.sv | 119 +++++++++++
 tb/tb_touch_detect.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/touch_pkg.sv
// rtl/touch_pkg.sv - shared state encoding and default tuning for touch_detect
package touch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_PROC = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  localparam int SHIFT_DEF    = 3;
  localparam int THRESH_DEF   = 8;
  localparam int HYST_DEF     = 2;
  localparam int DEBOUNCE_DEF = 3;

endpackage

// File: rtl/touch_baseline_iir.sv
// rtl/touch_baseline_iir.sv - slow IIR baseline with init seeding, touch freeze and saturating delta
module touch_baseline_iir
  import touch_pkg::*;
#(
  parameter int MSB   = 7,
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         upd_i,
  input  logic         freeze_i,
  input  logic [MSB:0] sample_i,
  output logic [MSB:0] baseline_o,
  output logic [MSB:0] delta_o,
  output logic [MSB:0] delta_next_o
);

  localparam int AW = MSB + 1 + SHIFT;

  logic [AW-1:0] acc_q, acc_d;
  logic          init_q, init_d;
  logic [MSB:0]  delta_q, delta_d;

  assign baseline_o   = acc_q[AW-1:SHIFT];
  assign delta_o      = delta_q;
  assign delta_next_o = delta_d;

  always_comb begin
    acc_d  = acc_q;
    init_d = init_q;
    if (init_q)
      delta_d = '0;
    else if (sample_i > baseline_o)
      delta_d = sample_i - baseline_o;
    else
      delta_d = '0;
    // The first sample seeds the baseline directly instead of ramping up from zero.
    if (upd_i) begin
      if (init_q) begin
        acc_d  = AW'(sample_i) << SHIFT;
        init_d = 1'b0;
      end else if (!freeze_i) begin
        acc_d = acc_q - AW'(baseline_o) + AW'(sample_i);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q   <= '0;
      init_q  <= 1'b1;
      delta_q <= '0;
    end else begin
      acc_q  <= acc_d;
      init_q <= init_d;
      if (upd_i)
        delta_q <= delta_d;
    end
  end

endmodule

// File: rtl/touch_detect.sv
// rtl/touch_detect.sv - measurement sequencer for sampler plus debounced hysteretic touch classifier
module touch_detect
  import touch_pkg::*;
#(
  parameter int MSB      = 7,
  parameter int SHIFT    = SHIFT_DEF,
  parameter int THRESH   = THRESH_DEF,
  parameter int HYST     = HYST_DEF,
  parameter int DEBOUNCE = DEBOUNCE_DEF,
  parameter int INTERVAL = 16
) (
  input  logic         clk_sampler,
  input  logic         rst_sampler_sync,
  input  logic         clksampleren,
  input  logic         enable,
  input  logic         sampler_finish,
  input  logic [MSB:0] sampler_data,
  output logic         detect_start,
  output logic         touch,
  output logic [MSB:0] baseline,
  output logic [MSB:0] delta,
  output logic         result_valid
);

  localparam logic [MSB:0] THR_ON  = (MSB+1)'(THRESH);
  localparam logic [MSB:0] THR_OFF = (MSB+1)'(THRESH - HYST);
  localparam logic [3:0]   DEB_W   = 4'(DEBOUNCE);
  localparam logic [15:0]  IVL_W   = 16'(INTERVAL);

  state_t       state_q;
  logic         start_q, touch_q, valid_q;
  logic [3:0]   cnt_q;
  logic [15:0]  wait_q;
  logic [MSB:0] sample_q;
  logic [MSB:0] delta_next;
  logic         upd, qualify;

  assign upd     = clksampleren && (state_q == ST_PROC);
  assign qualify = touch_q ? (delta_next < THR_OFF) : (delta_next >= THR_ON);

  touch_baseline_iir #(
    .MSB   (MSB),
    .SHIFT (SHIFT)
  ) u_iir (
    .clk_i        (clk_sampler),
    .rst_i        (rst_sampler_sync),
    .upd_i        (upd),
    .freeze_i     (touch_q),
    .sample_i     (sample_q),
    .baseline_o   (baseline),
    .delta_o      (delta),
    .delta_next_o (delta_next)
  );

  always_ff @(posedge clk_sampler or posedge rst_sampler_sync) begin
    if (rst_sampler_sync) begin
      state_q  <= ST_IDLE;
      start_q  <= 1'b0;
      touch_q  <= 1'b0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
      wait_q   <= '0;
      sample_q <= '0;
    end else begin
      valid_q <= 1'b0;
      if (clksampleren) begin
        case (state_q)
          ST_IDLE: if (enable) begin
            state_q <= ST_REQ;
            start_q <= 1'b1;
          end
          // Finish is honoured only here; the trailing strobe after start drops is ignored.
          ST_REQ: if (sampler_finish) begin
            sample_q <= sampler_data;
            start_q  <= 1'b0;
            state_q  <= ST_PROC;
          end
          ST_PROC: begin
            valid_q <= 1'b1;
            wait_q  <= IVL_W;
            if (qualify) begin
              if (cnt_q + 4'd1 == DEB_W) begin
                touch_q <= ~touch_q;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + 4'd1;
              end
            end else begin
              cnt_q <= '0;
            end
            if (IVL_W != 16'd0)
              state_q <= ST_WAIT;
            else if (enable) begin
              state_q <= ST_REQ;
              start_q <= 1'b1;
            end else
              state_q <= ST_IDLE;
          end
          ST_WAIT: begin
            wait_q <= wait_q - 16'd1;
            if (wait_q <= 16'd1) begin
              if (enable) begin
                state_q <= ST_REQ;
                start_q <= 1'b1;
              end else
                state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign detect_start = start_q;
  assign touch        = touch_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_touch_detect.sv
// tb/tb_touch_detect.sv - self-checking bench for touch_detect with stub sampler and reference model
module tb_touch_detect;

  localparam int MSB = 7, SHIFT = 3, TH = 8, HY = 2, DEB = 3, IVL = 16;

  logic       clk;
  logic       rst, clksampleren, enable, sampler_finish;
  logic [7:0] sampler_data;
  logic       detect_start, touch, result_valid;
  logic [7:0] baseline, delta;

  int vectors = 0;
  int miscompares = 0;

  touch_detect #(
    .MSB(MSB), .SHIFT(SHIFT), .THRESH(TH), .HYST(HY), .DEBOUNCE(DEB), .INTERVAL(IVL)
  ) dut (
    .clk_sampler      (clk),
    .rst_sampler_sync (rst),
    .clksampleren     (clksampleren),
    .enable           (enable),
    .sampler_finish   (sampler_finish),
    .sampler_data     (sampler_data),
    .detect_start     (detect_start),
    .touch            (touch),
    .baseline         (baseline),
    .delta            (delta),
    .result_valid     (result_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // stub sampler: counts enabled cycles of start, answers from a queue, trails finish
  logic [7:0] stub_q[$];
  int  stub_run = 5, stub_extra = 1, stub_cnt = 0, extra_left = 0;
  bit  stub_fin = 0;
  initial begin
    sampler_finish = 1'b0;
    sampler_data   = 8'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sampler_finish = 1'b0;
        stub_fin = 0;
        stub_cnt = 0;
      end else if (!stub_fin) begin
        if (detect_start && clksampleren && stub_cnt < stub_run) stub_cnt++;
        if (detect_start && stub_cnt >= stub_run && stub_q.size() > 0) begin
          sampler_data   = stub_q.pop_front();
          sampler_finish = 1'b1;
          stub_fin       = 1;
          extra_left     = stub_extra;
        end
      end else if (!detect_start && clksampleren) begin
        if (extra_left == 0) begin
          sampler_finish = 1'b0;
          stub_fin = 0;
          stub_cnt = 0;
        end else begin
          extra_left--;
          sampler_data = ~sampler_data;
        end
      end
    end
  end

  bit dither = 0;
  initial forever begin
    @(posedge clk);
    #2;
    if (dither) clksampleren = ($urandom_range(0, 3) != 0);
  end

  int rv_cnt = 0;
  initial forever begin
    @(negedge clk);
    if (result_valid === 1'b1) rv_cnt++;
  end

  // reference model: baseline is acc/2^SHIFT, touch changes after DEB qualifying results in a row
  int m_acc, m_init, m_touch, m_cnt, m_b, m_d;

  function automatic void model_reset();
    m_acc = 0; m_init = 1; m_touch = 0; m_cnt = 0; m_b = 0; m_d = 0;
  endfunction

  function automatic void model_step(input int s);
    int old_b;
    bit qual;
    old_b = m_acc / (1 << SHIFT);
    if (m_init != 0) begin
      m_acc = s * (1 << SHIFT);
      m_d = 0;
      m_init = 0;
    end else begin
      m_d = (s > old_b) ? s - old_b : 0;
      if (m_touch == 0) m_acc = m_acc - old_b + s;
    end
    qual = (m_touch != 0) ? (m_d < TH - HY) : (m_d >= TH);
    if (qual) begin
      m_cnt++;
      if (m_cnt == DEB) begin
        m_touch = 1 - m_touch;
        m_cnt = 0;
      end
    end else m_cnt = 0;
    m_b = m_acc / (1 << SHIFT);
  endfunction

  task automatic measure(input int s, output bit ok, output logic t, output logic [7:0] b, output logic [7:0] d);
    stub_q.push_back(8'(s));
    ok = 0; t = 1'bx; b = 8'hxx; d = 8'hxx;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (result_valid === 1'b1) begin
        ok = 1; t = touch; b = baseline; d = delta;
        break;
      end
    end
    model_step(s);
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; clksampleren = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({detect_start, touch, result_valid, baseline, delta} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got start=%b touch=%b valid=%b base=%0d delta=%0d, want all 0",
               detect_start, touch, result_valid, baseline, delta);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (detect_start !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_disabled: got start=%b, want 0", detect_start);
    end
    model_reset();
  endtask

  task automatic test_first_sample();
    bit seen = 0;
    int n0;
    stub_run = 5; enable = 1'b1; n0 = rv_cnt;
    stub_q.push_back(8'd40);
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (sampler_finish === 1'b1 && detect_start === 1'b1) seen = 1;
    end
    @(negedge clk);
    vectors++;
    if (!seen || detect_start !== 1'b0 || result_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL capture_edge: got seen=%0d start=%b valid=%b, want seen=1 start=0 valid=0",
               seen, detect_start, result_valid);
    end
    @(negedge clk);
    model_step(40);
    vectors++;
    if (result_valid !== 1'b1 || touch !== 1'b0 || baseline !== 8'd40 || delta !== 8'd0) begin
      miscompares++;
      $display("FAIL first_result: got valid=%b touch=%b base=%0d delta=%0d, want 1 0 40 0",
               result_valid, touch, baseline, delta);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (rv_cnt != n0 + 1) begin
      miscompares++;
      $display("FAIL first_pulse_count: got %0d pulses, want 1", rv_cnt - n0);
    end
  endtask

  task automatic test_stray_finish();
    bit ok; logic t; logic [7:0] b, d;
    int n0;
    stub_extra = 2; n0 = rv_cnt;
    measure(40, ok, t, b, d);
    vectors++;
    if (!ok || t !== 1'(m_touch) || b !== 8'(m_b) || d !== 8'(m_d)) begin
      miscompares++;
      $display("FAIL stray_result: got ok=%0d touch=%b base=%0d delta=%0d, want touch=%0d base=%0d delta=%0d",
               ok, t, b, d, m_touch, m_b, m_d);
    end
    repeat (30) @(negedge clk);
    vectors++;
    if (rv_cnt != n0 + 1 || detect_start !== 1'b1) begin
      miscompares++;
      $display("FAIL stray_single_capture: got pulses=%0d start=%b, want pulses=1 start=1",
               rv_cnt - n0, detect_start);
    end
    stub_extra = 1;
  endtask

  task automatic test_touch_debounce();
    bit ok; logic t; logic [7:0] b, d;
    int offs[7] = '{10, 5, 10, 0, 10, 10, 10};
    logic exp_t[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      measure(m_b + offs[i], ok, t, b, d);
      vectors++;
      if (!ok || t !== exp_t[i] || t !== 1'(m_touch) || b !== 8'(m_b) || d !== 8'(m_d)) begin
        miscompares++;
        $display("FAIL debounce[%0d]: got ok=%0d touch=%b base=%0d delta=%0d, want touch=%b base=%0d delta=%0d",
                 i, ok, t, b, d, exp_t[i], m_b, m_d);
      end
    end
  endtask

  task automatic test_hysteresis();
    bit ok; logic t; logic [7:0] b, d;
    int frozen;
    int offs[6] = '{6, 6, 6, 5, 5, 5};
    logic exp_t[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    frozen = m_b;
    for (int i = 0; i < 6; i++) begin
      measure(frozen + offs[i], ok, t, b, d);
      vectors++;
      if (!ok || t !== exp_t[i] || b !== 8'(frozen) || d !== 8'(offs[i])) begin
        miscompares++;
        $display("FAIL hysteresis[%0d]: got ok=%0d touch=%b base=%0d delta=%0d, want touch=%b base=%0d delta=%0d",
                 i, ok, t, b, d, exp_t[i], frozen, offs[i]);
      end
    end
  endtask

  task automatic test_enable_drop();
    bit ok, restarted = 0; logic t; logic [7:0] b, d;
    for (int i = 0; i < 60 && detect_start !== 1'b1; i++) @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    measure(m_b + 1, ok, t, b, d);
    vectors++;
    if (!ok || t !== 1'(m_touch) || b !== 8'(m_b) || d !== 8'(m_d)) begin
      miscompares++;
      $display("FAIL enable_drop_result: got ok=%0d touch=%b base=%0d delta=%0d, want touch=%0d base=%0d delta=%0d",
               ok, t, b, d, m_touch, m_b, m_d);
    end
    repeat (40) begin
      @(negedge clk);
      if (detect_start !== 1'b0) restarted = 1;
    end
    vectors++;
    if (restarted) begin
      miscompares++;
      $display("FAIL enable_drop_idle: got start raised after drop, want start held 0");
    end
  endtask

  task automatic test_clken_stall();
    bit ok = 0, moved = 0;
    int s;
    enable = 1'b1;
    for (int i = 0; i < 60 && detect_start !== 1'b1; i++) @(negedge clk);
    repeat (8) @(negedge clk);
    clksampleren = 1'b0;
    s = m_b + 2;
    stub_q.push_back(8'(s));
    repeat (10) begin
      @(negedge clk);
      if (detect_start !== 1'b1 || result_valid !== 1'b0) moved = 1;
    end
    vectors++;
    if (moved || sampler_finish !== 1'b1) begin
      miscompares++;
      $display("FAIL clken_stall: got moved=%0d finish=%b, want moved=0 finish=1", moved, sampler_finish);
    end
    clksampleren = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (result_valid === 1'b1) ok = 1;
    end
    model_step(s);
    vectors++;
    if (!ok || touch !== 1'(m_touch) || baseline !== 8'(m_b) || delta !== 8'(m_d)) begin
      miscompares++;
      $display("FAIL clken_resume: got ok=%0d touch=%b base=%0d delta=%0d, want touch=%0d base=%0d delta=%0d",
               ok, touch, baseline, delta, m_touch, m_b, m_d);
    end
  endtask

  task automatic test_random();
    bit ok; logic t; logic [7:0] b, d;
    int s;
    dither = 1;
    for (int i = 0; i < 40; i++) begin
      stub_run = $urandom_range(1, 8);
      if ($urandom_range(0, 7) == 0) s = $urandom_range(0, 255);
      else s = m_b + int'($urandom_range(0, 24)) - 8;
      if (s < 0) s = 0;
      if (s > 255) s = 255;
      measure(s, ok, t, b, d);
      vectors++;
      if (!ok || t !== 1'(m_touch) || b !== 8'(m_b) || d !== 8'(m_d)) begin
        miscompares++;
        $display("FAIL random[%0d] s=%0d: got ok=%0d touch=%b base=%0d delta=%0d, want touch=%0d base=%0d delta=%0d",
                 i, s, ok, t, b, d, m_touch, m_b, m_d);
      end
    end
    dither = 0;
    @(negedge clk);
    clksampleren = 1'b1;
    stub_run = 5;
  endtask

  task automatic test_reset_in_proc();
    bit ok, hit = 0; logic t; logic [7:0] b, d;
    for (int i = 0; i < 3; i++) measure(m_b + 20, ok, t, b, d);
    vectors++;
    if (!ok || t !== 1'b1 || t !== 1'(m_touch) || b !== 8'(m_b)) begin
      miscompares++;
      $display("FAIL pre_reset_touch: got ok=%0d touch=%b base=%0d, want touch=1 base=%0d", ok, t, b, m_b);
    end
    stub_q.push_back(8'd99);
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (sampler_finish === 1'b1 && detect_start === 1'b0) hit = 1;
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (!hit || {detect_start, touch, result_valid, baseline, delta} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_in_proc: got hit=%0d start=%b touch=%b valid=%b base=%0d delta=%0d, want all 0",
               hit, detect_start, touch, result_valid, baseline, delta);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    measure(40, ok, t, b, d);
    vectors++;
    if (!ok || t !== 1'b0 || b !== 8'd40 || d !== 8'd0) begin
      miscompares++;
      $display("FAIL reinit_after_reset: got ok=%0d touch=%b base=%0d delta=%0d, want 0 40 0", ok, t, b, d);
    end
  endtask

  task automatic test_iir_tracking();
    bit ok; logic t; logic [7:0] b, d;
    measure(48, ok, t, b, d);
    vectors++;
    if (!ok || b !== 8'd41 || d !== 8'd8) begin
      miscompares++;
      $display("FAIL iir_first_step: got ok=%0d base=%0d delta=%0d, want base=41 delta=8", ok, b, d);
    end
    for (int i = 0; i < 40; i++) begin
      measure(48, ok, t, b, d);
      vectors++;
      if (!ok || t !== 1'(m_touch) || b !== 8'(m_b) || d !== 8'(m_d)) begin
        miscompares++;
        $display("FAIL iir_track[%0d]: got ok=%0d touch=%b base=%0d delta=%0d, want touch=%0d base=%0d delta=%0d",
                 i, ok, t, b, d, m_touch, m_b, m_d);
      end
    end
    vectors++;
    if (b !== 8'd48) begin
      miscompares++;
      $display("FAIL iir_converged: got base=%0d, want 48", b);
    end
    measure(20, ok, t, b, d);
    vectors++;
    if (!ok || d !== 8'd0 || b !== 8'(m_b)) begin
      miscompares++;
      $display("FAIL delta_floor: got ok=%0d base=%0d delta=%0d, want base=%0d delta=0", ok, b, d, m_b);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; clksampleren = 1'b1;
    model_reset();
    test_reset();
    test_first_sample();
    test_stray_finish();
    test_touch_debounce();
    test_hysteresis();
    test_enable_drop();
    test_clken_stall();
    test_random();
    test_reset_in_proc();
    test_iir_tracking();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
